// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot encoder family.
//   enc_mode_e : how a word with several bits set maps to a binary index
//   flags_t    : word classification carried down the pipeline
//   bin_width  : index width for a given one-hot width (never below 1)
package onehot_pkg;

  typedef enum logic [1:0] {
    ENC_OR  = 2'd0,  // OR of all set indices, no priority
    ENC_LSB = 2'd1,  // lowest set index wins
    ENC_MSB = 2'd2   // highest set index wins
  } enc_mode_e;

  typedef struct packed {
    logic zero;
    logic multi;
  } flags_t;

  function automatic int bin_width(input int values);
    int w;
    w = $clog2(values);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/onehot_encode_comb.sv
// Purely combinational one-hot to binary encoder with word classification.
// Ports:
//   vec   : one-hot input word (VALUES bits)
//   bin   : encoded index (bin_width(VALUES) bits), 0 for an all-zero word
//   zero  : no bit set
//   multi : more than one bit set
module onehot_encode_comb
  import onehot_pkg::*;
#(
  parameter int        VALUES = 8,
  parameter enc_mode_e MODE   = ENC_OR,
  localparam int       BIN_W  = bin_width(VALUES)
) (
  input  logic [VALUES-1:0] vec,
  output logic [BIN_W-1:0]  bin,
  output logic              zero,
  output logic              multi
);

  // 'seen' tracks whether a lower bit was already set, which gives both the
  // LSB priority and the multi-hot detection without a popcount adder.
  logic seen;

  always_comb begin
    bin   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < VALUES; i++) begin
      if (vec[i]) begin
        case (MODE)
          ENC_OR:  bin = bin | BIN_W'(i);
          ENC_LSB: if (!seen) bin = BIN_W'(i);
          default: bin = BIN_W'(i);  // ENC_MSB: last set bit scanned wins
        endcase
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/onehot_encode_pipe.sv
// Two-stage, valid/ready handshaked one-hot to binary encoder.
// S1 holds the raw word; S2 holds the encoded index and flags.
// A saturating counter tallies accepted words that are zero or multi-hot.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_vec/in_valid     : upstream word and its valid
//   in_ready            : upstream word is accepted this cycle
//   out_bin/out_zero/
//   out_multi/out_valid : downstream result and its valid
//   out_ready           : downstream accepts this cycle
//   err_cnt/err_clr     : malformed-word count and its synchronous clear
module onehot_encode_pipe
  import onehot_pkg::*;
#(
  parameter int        VALUES = 8,
  parameter enc_mode_e MODE   = ENC_OR,
  parameter int        CNT_W  = 8,
  localparam int       BIN_W  = bin_width(VALUES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VALUES-1:0] in_vec,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BIN_W-1:0]  out_bin,
  output logic              out_zero,
  output logic              out_multi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_clr
);

  logic              s1_valid_reg;
  logic [VALUES-1:0] s1_vec_reg;
  logic              s2_valid_reg;
  logic [BIN_W-1:0]  s2_bin_reg;
  flags_t            s2_flags_reg;
  logic [CNT_W-1:0]  err_cnt_reg;
  logic [CNT_W-1:0]  err_cnt_next;

  logic              adv1;
  logic              adv2;
  logic              in_fire;
  logic              in_zero;
  logic              in_multi;
  logic              in_seen;
  logic [BIN_W-1:0]  enc_bin;
  logic              enc_zero;
  logic              enc_multi;

  // Each stage moves when it is empty or the stage after it moves, so a full
  // pipe with out_ready=1 still takes a new word every cycle.
  assign adv2     = !s2_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;
  assign in_fire  = in_valid && adv1;

  // Classification of the incoming word, needed at S1 capture for the counter.
  always_comb begin
    in_seen  = 1'b0;
    in_multi = 1'b0;
    for (int i = 0; i < VALUES; i++) begin
      if (in_vec[i]) begin
        in_multi = in_multi | in_seen;
        in_seen  = 1'b1;
      end
    end
  end

  assign in_zero = ~|in_vec;

  onehot_encode_comb #(
    .VALUES (VALUES),
    .MODE   (MODE)
  ) u_enc (
    .vec   (s1_vec_reg),
    .bin   (enc_bin),
    .zero  (enc_zero),
    .multi (enc_multi)
  );

  // Clear first, then count, so clear plus a bad word in one cycle yields 1.
  always_comb begin
    err_cnt_next = err_clr ? '0 : err_cnt_reg;
    if (in_fire && (in_zero || in_multi) && (err_cnt_next != {CNT_W{1'b1}}))
      err_cnt_next = err_cnt_next + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_vec_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_bin_reg   <= '0;
      s2_flags_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (adv1) begin
        s1_valid_reg <= in_valid;
        if (in_valid)
          s1_vec_reg <= in_vec;
      end
      if (adv2) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_bin_reg         <= enc_bin;
          s2_flags_reg.zero  <= enc_zero;
          s2_flags_reg.multi <= enc_multi;
        end
      end
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_bin   = s2_bin_reg;
  assign out_zero  = s2_flags_reg.zero;
  assign out_multi = s2_flags_reg.multi;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: doc/onehot_encode_pipe.md
Name: onehot_encode_pipe

Overview:
- Pipelined, handshaked successor to the combinational one-hot-to-binary decoder.
- Encodes a VALUES-wide one-hot word to binary with a selectable encoding mode.
- Classifies each word as valid, zero or multi-hot, and keeps a saturating count of malformed words.
- Sits between one-hot arbiters/grant vectors and binary-indexed consumers, with full valid/ready back-pressure.

Parameters:
VALUES, 8, width of the one-hot input vector (>=2)
MODE, ENC_OR, encoding mode from onehot_pkg: ENC_OR (OR of set indices, no priority), ENC_LSB (lowest set index wins), ENC_MSB (highest set index wins)
CNT_W, 8, width of the saturating malformed-word counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_vec  in  VALUES  one-hot input word
in_valid  in  1  in_vec is valid
in_ready  out  1  block accepts in_vec this cycle
out_bin  out  BIN_W=$clog2(VALUES)  encoded index
out_zero  out  1  accepted word had no bit set
out_multi  out  1  accepted word had more than one bit set
out_valid  out  1  out_* fields valid
out_ready  in  1  downstream accepts this cycle
err_cnt  out  CNT_W  saturating count of accepted words with zero or multi set
err_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous, active-low. While rst_n=0, all of the following are 0: stage valids, out_valid, out_bin, out_zero, out_multi, err_cnt. in_ready=1 once out of reset; in-flight words are discarded.
- Pipeline: two register stages, S1 and S2.
  - S1 captures in_vec and computes flags: zero = ~|vec; multi = vec has more than one bit set (popcount>1, no adder chain required).
  - S2 captures the encoded index and flags. Latency in_valid&&in_ready -> out_valid is exactly 2 cycles when there is no back-pressure.
- Handshake:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, combinational from state and out_ready only, never from in_valid.
  - A transfer occurs when valid&&ready on either side.
  - Full throughput of 1 word/cycle with out_ready held at 1.
  - Output fields hold stable while out_valid=1 and out_ready=0.
  - Words are never dropped, duplicated or reordered.
- Encoding:
  - ENC_OR: out_bin = bitwise OR of all set indices; multi-hot yields the OR result.
  - ENC_LSB: lowest set index. ENC_MSB: highest set index.
  - Zero input: out_bin=0, out_zero=1, in all modes.
  - Indices >= VALUES do not exist. When VALUES is not a power of two, the unused codes never appear for a legal one-hot input.
- Error counter:
  - Increments at the S1 capture (in transfer) when zero|multi is true.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - err_clr=1 sets err_cnt to 0 on the next edge. If an erroneous transfer occurs in the same cycle as err_clr, err_cnt becomes 1 (clear then count).
- Simultaneous events: a full pipe with out_ready=1 accepts a new input in the same cycle the oldest word leaves.

Decomposition:
- Package onehot_pkg:
  - enum enc_mode_e {ENC_OR, ENC_LSB, ENC_MSB}.
  - function bin_width(values), returning max(1,$clog2(values)).
  - typedef for the flag struct {zero, multi}.
- Sub-module onehot_encode_comb: purely combinational, parametrised by VALUES and MODE, produces bin, zero and multi.
- onehot_encode_pipe instantiates onehot_encode_comb and adds the handshake stages and the counter.

Test Plan:
- MODE=ENC_OR, VALUES=8, out_ready=1; stream 8'h01,8'h02,...,8'h80 on consecutive cycles -> out_bin 0..7 on 8 consecutive cycles starting 2 cycles after the first transfer; flags 0; err_cnt=0.
- Malformed words: 8'h00 then 8'h14 -> first word out_zero=1, out_bin=0; second word out_multi=1 with out_bin 6 in ENC_OR, 2 in ENC_LSB, 4 in ENC_MSB; err_cnt=2.
- Back-pressure: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 words accepted, then in_ready=0; outputs stable; on release, all words emerge in order with none lost.
- Saturation: CNT_W=2, 5 zero words -> err_cnt reads 1,2,3,3,3. Then err_clr together with an erroneous word -> err_cnt=1. Then err_clr alone -> 0.
- Async reset: assert rst_n=0 mid-stream with both stages full -> out_valid and err_cnt drop to 0 immediately, without a clock edge; after release, the first new word appears 2 cycles after its transfer.
- VALUES=5 (non-power-of-two): each single-bit input 1..16 -> out_bin 0..4 with BIN_W=3.
